// File: rtl/mac_psum_accum.sv
// Per-lane saturating partial-sum accumulators with per-lane result FIFOs.
// A round-robin arbiter drains the FIFOs onto one lane-tagged valid/ready port.
module mac_psum_accum #(
    parameter int N_LANE = 8,
    parameter int W_PSUM = 32,
    parameter int W_ACC  = 40,
    parameter int DEPTH  = 4,
    parameter int W_LID  = $clog2(N_LANE)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       bias_enable_i,
    input  logic [N_LANE-1:0]          in_valid_i,
    output logic [N_LANE-1:0]          in_ready_o,
    input  logic [N_LANE*W_PSUM-1:0]   in_psum_i,
    input  logic [N_LANE-1:0]          in_inter_end_i,
    input  logic [N_LANE-1:0]          in_accum_end_i,
    input  logic [N_LANE*32-1:0]       bias_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [W_LID-1:0]           out_lane_o,
    output logic [31:0]                out_data_o,
    output logic                       out_end_o,
    output logic [N_LANE-1:0]          sat_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [N_LANE-1:0]        nonempty;
    logic [N_LANE-1:0]        pop;
    logic [N_LANE-1:0][32:0]  head_word;
    logic [W_LID-1:0]         rr_ptr_reg;
    logic [W_LID-1:0]         rr_ptr_next;
    logic [W_LID-1:0]         grant;
    logic [W_LID:0]           idx;
    logic [W_LID:0]           rr_inc;
    logic                     any_valid;
    logic                     handshake;

    generate
        for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
            logic signed [W_ACC-1:0] acc_reg;
            logic [AW-1:0]           wr_ptr_reg;
            logic [AW-1:0]           rd_ptr_reg;
            logic [AW:0]             count_reg;
            logic                    sat_reg;
            logic [32:0]             mem [DEPTH];
            logic [W_PSUM-1:0]       psum;
            logic [31:0]             bias;
            logic [W_ACC:0]          sum1_wide;
            logic [W_ACC:0]          sum2_wide;
            logic [W_ACC-1:0]        sum1;
            logic [W_ACC-1:0]        sum2;
            logic [W_ACC-1:0]        sum_fin;
            logic [31:0]             res32;
            logic                    ovf1, ovf2, fits32, clamp;
            logic                    use_bias, accept, push;

            assign psum     = in_psum_i[gi*W_PSUM +: W_PSUM];
            assign bias     = bias_i[gi*32 +: 32];
            assign accept   = in_valid_i[gi] & in_ready_o[gi];
            assign push     = accept & (in_inter_end_i[gi] | in_accum_end_i[gi]);
            assign use_bias = in_accum_end_i[gi] & bias_enable_i;

            // One guard bit: overflow iff the two top bits of the wide sum disagree
            assign sum1_wide = {acc_reg[W_ACC-1], acc_reg}
                             + {{(W_ACC+1-W_PSUM){psum[W_PSUM-1]}}, psum};
            assign ovf1 = sum1_wide[W_ACC] ^ sum1_wide[W_ACC-1];
            assign sum1 = ovf1 ? {sum1_wide[W_ACC], {(W_ACC-1){~sum1_wide[W_ACC]}}}
                               : sum1_wide[W_ACC-1:0];

            assign sum2_wide = {sum1[W_ACC-1], sum1} + {{(W_ACC+1-32){bias[31]}}, bias};
            assign ovf2 = sum2_wide[W_ACC] ^ sum2_wide[W_ACC-1];
            assign sum2 = ovf2 ? {sum2_wide[W_ACC], {(W_ACC-1){~sum2_wide[W_ACC]}}}
                               : sum2_wide[W_ACC-1:0];

            assign sum_fin = use_bias ? sum2 : sum1;
            assign fits32  = (&sum_fin[W_ACC-1:31]) | ~(|sum_fin[W_ACC-1:31]);
            assign res32   = fits32 ? sum_fin[31:0]
                                    : {sum_fin[W_ACC-1], {31{~sum_fin[W_ACC-1]}}};
            assign clamp   = ovf1 | (use_bias & ovf2) | (push & ~fits32);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_reg    <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    sat_reg    <= 1'b0;
                end else if (flush_i) begin
                    acc_reg    <= '0;
                    wr_ptr_reg <= '0;
                    rd_ptr_reg <= '0;
                    count_reg  <= '0;
                    sat_reg    <= 1'b0;
                end else begin
                    if (accept)
                        acc_reg <= in_accum_end_i[gi] ? '0 : sum_fin;
                    if (push)
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                    if (pop[gi])
                        rd_ptr_reg <= rd_ptr_reg + 1'b1;
                    if (push && !pop[gi])
                        count_reg <= count_reg + 1'b1;
                    else if (!push && pop[gi])
                        count_reg <= count_reg - 1'b1;
                    if (accept && clamp)
                        sat_reg <= 1'b1;
                end
            end

            // Storage needs no reset: occupancy is tracked by count_reg
            always_ff @(posedge clk) begin
                if (push && !flush_i)
                    mem[wr_ptr_reg] <= {in_accum_end_i[gi], res32};
            end

            assign in_ready_o[gi] = (count_reg != FULL);
            assign nonempty[gi]   = (count_reg != '0);
            assign head_word[gi]  = mem[rd_ptr_reg];
            assign sat_o[gi]      = sat_reg;
            assign pop[gi]        = handshake & (grant == W_LID'(gi));
        end
    endgenerate

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 0; i < N_LANE; i++) begin
            idx = {1'b0, rr_ptr_reg} + (W_LID+1)'(i);
            if (idx >= (W_LID+1)'(N_LANE))
                idx = idx - (W_LID+1)'(N_LANE);
            if (!any_valid && nonempty[idx[W_LID-1:0]]) begin
                grant     = idx[W_LID-1:0];
                any_valid = 1'b1;
            end
        end
    end

    assign handshake   = any_valid & out_ready_i;
    assign out_valid_o = any_valid;
    assign out_lane_o  = grant;
    assign out_data_o  = any_valid ? head_word[grant][31:0] : 32'd0;
    assign out_end_o   = any_valid & head_word[grant][32];

    always_comb begin
        rr_inc      = {1'b0, grant} + (W_LID+1)'(1);
        rr_ptr_next = rr_ptr_reg;
        if (handshake)
            rr_ptr_next = (rr_inc == (W_LID+1)'(N_LANE)) ? '0 : rr_inc[W_LID-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_reg <= '0;
        else if (flush_i)
            rr_ptr_reg <= '0;
        else
            rr_ptr_reg <= rr_ptr_next;
    end
endmodule

// File: tb/tb_mac_psum_accum.sv
// Directed bench for mac_psum_accum: accumulation, bias, saturation,
// round-robin draining, FIFO backpressure and asynchronous reset.
module tb_mac_psum_accum;
    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          bias_en;
    logic [7:0]    in_valid;
    logic [7:0]    in_ready;
    logic [255:0]  in_psum;
    logic [7:0]    in_inter;
    logic [7:0]    in_accum;
    logic [255:0]  bias;
    logic          out_valid;
    logic          out_ready;
    logic [2:0]    out_lane;
    logic [31:0]   out_data;
    logic          out_end;
    logic [7:0]    sat;

    int n_cmp = 0;
    int n_err = 0;

    mac_psum_accum dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush_i       (flush),
        .bias_enable_i (bias_en),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .in_psum_i     (in_psum),
        .in_inter_end_i(in_inter),
        .in_accum_end_i(in_accum),
        .bias_i        (bias),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .out_lane_o    (out_lane),
        .out_data_o    (out_data),
        .out_end_o     (out_end),
        .sat_o         (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int l, input logic [31:0] p, input logic ie, input logic ae);
        in_valid           = '0;
        in_valid[l]        = 1'b1;
        in_psum[l*32 +: 32] = p;
        in_inter[l]        = ie;
        in_accum[l]        = ae;
        step();
        in_valid = '0;
        in_inter = '0;
        in_accum = '0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] l, input logic [31:0] d,
                             input logic e);
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_lane"},  64'(out_lane),  64'(l));
        check({tag, "_data"},  64'(out_data),  64'(d));
        check({tag, "_end"},   64'(out_end),   64'(e));
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; bias_en = 1'b0;
        in_valid = '0; in_psum = '0; in_inter = '0; in_accum = '0;
        bias = '0; out_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step();
        $display("reset state");
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_lane",  64'(out_lane),  64'd0);
        check("rst_data",  64'(out_data),  64'd0);
        check("rst_end",   64'(out_end),   64'd0);
        check("rst_sat",   64'(sat),       64'd0);
        check("rst_ready", 64'(in_ready),  64'hFF);

        // Lane 0: 5 + 7 - 2 = 10, then a fresh sequence starts from 0
        beat(0, 32'd5, 1'b0, 1'b0);
        beat(0, 32'd7, 1'b0, 1'b0);
        check("l0_no_emit", 64'(out_valid), 64'd0);
        beat(0, 32'hFFFF_FFFE, 1'b0, 1'b1);
        $display("lane0 sum result data=%0d", out_data);
        check_out("l0_sum", 3'd0, 32'd10, 1'b1);
        step();
        check("l0_popped", 64'(out_valid), 64'd0);
        beat(0, 32'd3, 1'b0, 1'b1);
        $display("lane0 restart result data=%0d", out_data);
        check_out("l0_restart", 3'd0, 32'd3, 1'b1);
        step();

        // Lane 3: inter_end 100, then accum_end 50 with bias 1000
        bias_en = 1'b1;
        bias[3*32 +: 32] = 32'd1000;
        beat(3, 32'd100, 1'b1, 1'b0);
        $display("lane3 inter result data=%0d", out_data);
        check_out("l3_inter", 3'd3, 32'd100, 1'b0);
        beat(3, 32'd50, 1'b0, 1'b1);
        $display("lane3 final result data=%0d", out_data);
        check_out("l3_final", 3'd3, 32'd1150, 1'b1);
        step();
        bias_en = 1'b0;

        // Saturation at the 32-bit output, both polarities
        beat(1, 32'h7FFF_FFFF, 1'b0, 1'b0);
        check("l1_sat_pre", 64'(sat), 64'h00);
        beat(1, 32'h7FFF_FFFF, 1'b0, 1'b1);
        $display("lane1 sat result data=0x%0h sat=0x%0h", out_data, sat);
        check_out("l1_sat", 3'd1, 32'h7FFF_FFFF, 1'b1);
        check("l1_sat_flag", 64'(sat), 64'h02);
        beat(2, 32'h8000_0000, 1'b0, 1'b0);
        beat(2, 32'h8000_0000, 1'b0, 1'b1);
        $display("lane2 sat result data=0x%0h sat=0x%0h", out_data, sat);
        check_out("l2_sat", 3'd2, 32'h8000_0000, 1'b1);
        check("l2_sat_flag", 64'(sat), 64'h06);
        step();
        check("sat_sticky", 64'(sat), 64'h06);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_sat", 64'(sat), 64'h00);

        // All lanes at once: round-robin from rr_ptr 0
        for (int l = 0; l < 8; l++) in_psum[l*32 +: 32] = 32'(10 + l);
        in_valid = 8'hFF; in_accum = 8'hFF;
        step();
        in_valid = '0; in_accum = '0;
        for (int k = 0; k < 8; k++) begin
            $display("rr drain lane=%0d data=%0d", out_lane, out_data);
            check_out("rr_all", 3'(k), 32'(10 + k), 1'b1);
            step();
        end
        check("rr_all_empty", 64'(out_valid), 64'd0);
        in_psum[2*32 +: 32] = 32'd20;
        in_psum[5*32 +: 32] = 32'd50;
        in_valid = 8'b0010_0100; in_accum = 8'b0010_0100;
        step();
        in_valid = '0; in_accum = '0;
        $display("rr pair lane=%0d data=%0d", out_lane, out_data);
        check_out("rr_pair_a", 3'd2, 32'd20, 1'b1);
        step();
        $display("rr pair lane=%0d data=%0d", out_lane, out_data);
        check_out("rr_pair_b", 3'd5, 32'd50, 1'b1);
        step();
        check("rr_pair_empty", 64'(out_valid), 64'd0);

        // Backpressure on lane 4 with DEPTH 4
        out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            beat(4, 32'(k), 1'b0, 1'b1);
            $display("bp push %0d ready=0x%0h", k, in_ready);
            if (k == 3) check("bp_ready_3", 64'(in_ready[4]), 64'd1);
        end
        check("bp_ready_full", 64'(in_ready[4]), 64'd0);
        check_out("bp_head", 3'd4, 32'd1, 1'b1);
        in_valid[4] = 1'b1; in_psum[4*32 +: 32] = 32'd5; in_accum[4] = 1'b1;
        step();
        check("bp_held", 64'(in_ready[4]), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_after_pop", 64'(in_ready[4]), 64'd1);
        check("bp_head2", 64'(out_data), 64'd2);
        step();
        in_valid = '0; in_accum = '0;
        check("bp_refull", 64'(in_ready[4]), 64'd0);
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            $display("bp drain lane=%0d data=%0d", out_lane, out_data);
            check_out("bp_drain", 3'd4, 32'(k), 1'b1);
            step();
        end
        check("bp_empty", 64'(out_valid), 64'd0);

        // Asynchronous reset while results are queued
        out_ready = 1'b0;
        beat(6, 32'd9, 1'b0, 1'b1);
        beat(7, 32'd11, 1'b1, 1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset valid=%0d ready=0x%0h", out_valid, in_ready);
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_ready", 64'(in_ready),  64'hFF);
        check("arst_data",  64'(out_data),  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        beat(7, 32'd4, 1'b0, 1'b1);
        $display("post reset lane=%0d data=%0d", out_lane, out_data);
        check_out("arst_fresh", 3'd7, 32'd4, 1'b1);
        step();
        check("arst_empty", 64'(out_valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mac_psum_accum.md
# mac_psum_accum

Parametrised partial-sum accumulator that sits behind the MAC lane group and turns per-lane 32-bit partial sums into finished output-feature-map words. Each of N_LANE lanes keeps a saturating wide accumulator, emits a result on inter_end (running value) or accum_end (final value, optional bias, accumulator cleared) and buffers results in a per-lane FIFO. A round-robin arbiter drains all lane FIFOs onto one valid/ready output port tagged with the lane index. Integer (I9-derived) partial sums only.

## Interface
- N_LANE, 8, number of lanes (≥2)
- W_PSUM, 32, signed partial-sum width per lane
- W_ACC, 40, signed accumulator width (≥ W_PSUM)
- DEPTH, 4, result FIFO entries per lane (power of 2, ≥2)
- W_LID, $clog2(N_LANE), lane-index width
---
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of accumulators, FIFOs, sticky flags
- bias_enable_i  in  1  add bias on accum_end beats
- in_valid_i  in  N_LANE  per-lane beat valid
- in_ready_o  out  N_LANE  per-lane ready (= lane FIFO not full)
- in_psum_i  in  N_LANE*W_PSUM  signed partial sums, lane l at [l*W_PSUM +: W_PSUM]
- in_inter_end_i  in  N_LANE  emit running value, keep accumulating
- in_accum_end_i  in  N_LANE  emit final value, clear accumulator
- bias_i  in  N_LANE*32  signed per-lane bias, sampled on accum_end beat
- out_valid_o  out  1  result available
- out_ready_i  in  1  consumer accepts
- out_lane_o  out  W_LID  lane index of result
- out_data_o  out  32  signed result
- out_end_o  out  1  1 = final (accum_end) result, 0 = intermediate
- sat_o  out  N_LANE  sticky per-lane saturation flag

## Operation
- Beat on lane l accepted iff in_valid_i[l] & in_ready_o[l]; unaccepted beats have no effect.
- Accepted beat: sum = acc[l] + sext(psum), saturated to W_ACC signed range; if accum_end & bias_enable_i, sum additionally + sext(bias), saturated again.
- Neither end flag: acc[l] <= sum, nothing emitted.
- inter_end only: push {sat32(sum), end=0}; acc[l] <= sum.
- accum_end (with or without inter_end): push {sat32(sum), end=1}; acc[l] <= 0. accum_end wins.
- sat32: clamp to [-2^31, 2^31-1]. Any clamp (W_ACC or 32-bit) sets sat_o[l]; sticky until flush_i or reset.
- in_ready_o[l] = (count[l] != DEPTH), from registered count; independent of in_valid_i and out_ready_i (no combinational path from output side).
- Non-emitting beats also require ready (uniform rule).
- Arbiter: candidates = lanes with non-empty FIFO. Grant = first candidate searching from rr_ptr upward, wrapping. out_* driven combinationally from granted FIFO head; out_valid_o = any candidate.
- On out_valid_o & out_ready_i: pop granted FIFO; rr_ptr <= grant+1 mod N_LANE. No handshake: rr_ptr holds; grant may change only if a higher-priority lane becomes non-empty (output not required stable while stalled).
- Same-cycle push and pop on one lane: both occur, count unchanged. Push when count==DEPTH impossible (ready low).
- flush_i: all acc <= 0, FIFOs emptied, sat_o <= 0, rr_ptr <= 0; beats in the flush cycle are discarded; takes priority over all other updates.

## Timing
- Reset values: acc 0, FIFOs empty, rr_ptr 0, out_valid_o 0, out_lane_o 0, out_data_o 0, out_end_o 0, sat_o 0, in_ready_o all 1.
- Latency: emitting beat accepted at edge t → out_valid_o high in cycle after t (1 cycle) if that lane wins arbitration.
- Throughput: 1 beat/cycle per lane in; 1 result/cycle out overall.
- Reset asserted mid-operation: all state to reset values immediately (asynchronous); queued results lost.

## Test plan
- Lane 0 beats psum 5, 7, -2 with accum_end on third, bias off → one result lane 0, data 10, end 1; next sequence starts from 0.
- Lane 3 psum 100 inter_end, 50 accum_end, bias_enable 1, bias 1000 → results 100 end 0, then 1150 end 1.
- Lane 1 psums 0x7FFF_FFFF ×2 accum_end on second → data 0x7FFF_FFFF, sat_o[1]=1; stays 1 until flush_i pulse clears it.
- All 8 lanes push one accum_end result same cycle, out_ready_i=1 → outputs lanes 0,1,…,7 on consecutive cycles; then lanes 2 and 5 push with rr_ptr 0 → order 2,5.
- out_ready_i=0, lane 4 sends 5 accum_end results (DEPTH 4) → in_ready_o[4] low after 4th accepted; 5th held; one pop → 5th accepted next cycle; drained data in order.
- rst_n low while FIFOs hold data → out_valid_o 0, in_ready_o all 1 immediately; after release fresh sums start from 0.
